// File: rtl/load_store_unit.sv
// load_store_unit: one-request-at-a-time initiator for the byte-addressed, big-endian data memory.
// Define ALIGN_CHECK_EN to also reject misaligned halfword/word requests.
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Store,
    input  logic [1:0]  Size,
    input  logic        SE,
    input  logic [8:0]  Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] RData,
    output logic        MemEnable,
    output logic        MemReadWrite,
    output logic        MemSE,
    output logic [1:0]  MemSize,
    output logic [8:0]  MemAddress,
    output logic [31:0] MemDataIn,
    input  logic [31:0] MemDataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        fault_q;

    logic        accept_ok;
    logic        accept_bad;
    logic        capture_load;
    logic [1:0]  last_off;
    logic [9:0]  end_addr;
    logic        range_fault;
    logic        align_fault;
    logic        req_fault;
    logic [31:0] load_data;

    // Offset of the last byte touched by the request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        last_off = 2'd3;
        case (Size)
            2'b00:   last_off = 2'd0;
            2'b01:   last_off = 2'd1;
            default: last_off = 2'd3;
        endcase
    end

    // The extra carry bit catches any access that would run past byte 511 rather than wrap.
    assign end_addr    = {1'b0, Addr} + {8'd0, last_off};
    assign range_fault = end_addr[9];

`ifdef ALIGN_CHECK_EN
    assign align_fault = ((Size == 2'b01) && Addr[0]) ||
                         (Size[1] && (Addr[1:0] != 2'b00));
`else
    assign align_fault = 1'b0;
`endif

    assign req_fault = range_fault | align_fault;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept_ok    = 1'b0;
        accept_bad   = 1'b0;
        capture_load = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (req_fault) begin
                        accept_bad = 1'b1;
                        state_nxt  = RESP;
                    end else begin
                        accept_ok  = 1'b1;
                        state_nxt  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    capture_load = ~MemReadWrite;
                    state_nxt    = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Ready = (state == IDLE);
    assign Done  = (state == RESP);
    assign Fault = (state == RESP) & fault_q;

    // The Mem* registers double as the latched request; a rejected request leaves them untouched.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt     <= 4'd0;
            MemEnable    <= 1'b0;
            MemReadWrite <= 1'b0;
            MemSE        <= 1'b0;
            MemSize      <= 2'b00;
            MemAddress   <= 9'd0;
            MemDataIn    <= 32'd0;
        end else if (accept_ok) begin
            wait_cnt     <= WAIT_INIT;
            MemEnable    <= 1'b1;
            MemReadWrite <= Store;
            MemSE        <= SE;
            MemSize      <= Size[1] ? 2'b10 : Size;
            MemAddress   <= Addr;
            MemDataIn    <= WData;
        end else if (state == ACCESS) begin
            if (wait_cnt != 4'd0) begin
                wait_cnt  <= wait_cnt - 4'd1;
            end else begin
                MemEnable <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fault_q <= 1'b0;
        end else if (accept_ok || accept_bad) begin
            fault_q <= accept_bad;
        end
    end

    // Extension is done here from raw bits so RData never depends on the memory's own SE handling.
    always_comb begin
        load_data = MemDataOut;
        case (MemSize)
            2'b00:   load_data = {{24{MemSE & MemDataOut[7]}},  MemDataOut[7:0]};
            2'b01:   load_data = {{16{MemSE & MemDataOut[15]}}, MemDataOut[15:0]};
            default: load_data = MemDataOut;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RData <= 32'd0;
        end else if (capture_load) begin
            RData <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (WAIT_CYCLES 0 and 3), each with a
// big-endian memory model; expectations come from a byte-array reference model.
module tb_load_store_unit;

    localparam int W0 = 0;
    localparam int W1 = 3;

    typedef struct {
        bit        store;
        bit [1:0]  size;
        bit        se;
        bit [8:0]  addr;
        bit [31:0] wdata;
        bit        fault;
        bit [31:0] rdata;
        int        done_edge;
        int        en_cycles;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        req     [2];
    logic        store   [2];
    logic [1:0]  size    [2];
    logic        se      [2];
    logic [8:0]  addr    [2];
    logic [31:0] wdata   [2];
    logic        ready   [2];
    logic        done    [2];
    logic        fault   [2];
    logic [31:0] rdata   [2];
    logic        mem_en  [2];
    logic        mem_rw  [2];
    logic        mem_se  [2];
    logic [1:0]  mem_size[2];
    logic [8:0]  mem_addr[2];
    logic [31:0] mem_din [2];
    logic [31:0] mem_dout[2];

    logic [7:0]  mem_model [2][512];
    logic [7:0]  ref_mem   [2][512];
    logic [31:0] ref_rdata [2];
    exp_t        sbq [2][$];
    int          en_cnt [2];

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    load_store_unit #(.WAIT_CYCLES(W0)) u_dut0 (
        .Clk(clk), .Reset_n(rst_n), .Req(req[0]), .Store(store[0]), .Size(size[0]),
        .SE(se[0]), .Addr(addr[0]), .WData(wdata[0]), .Ready(ready[0]), .Done(done[0]),
        .Fault(fault[0]), .RData(rdata[0]), .MemEnable(mem_en[0]), .MemReadWrite(mem_rw[0]),
        .MemSE(mem_se[0]), .MemSize(mem_size[0]), .MemAddress(mem_addr[0]),
        .MemDataIn(mem_din[0]), .MemDataOut(mem_dout[0])
    );

    load_store_unit #(.WAIT_CYCLES(W1)) u_dut1 (
        .Clk(clk), .Reset_n(rst_n), .Req(req[1]), .Store(store[1]), .Size(size[1]),
        .SE(se[1]), .Addr(addr[1]), .WData(wdata[1]), .Ready(ready[1]), .Done(done[1]),
        .Fault(fault[1]), .RData(rdata[1]), .MemEnable(mem_en[1]), .MemReadWrite(mem_rw[1]),
        .MemSE(mem_se[1]), .MemSize(mem_size[1]), .MemAddress(mem_addr[1]),
        .MemDataIn(mem_din[1]), .MemDataOut(mem_dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int wait_of(int l);
        return (l == 0) ? W0 : W1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: writes land on the clock edge, read data is presented with random upper bits.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (mem_en[l] === 1'b1 && mem_rw[l] === 1'b1) begin
                for (int i = 0; i < nbytes(mem_size[l]); i++)
                    mem_model[l][9'(mem_addr[l] + 9'(i))] <= mem_din[l][8*(nbytes(mem_size[l])-1-i) +: 8];
            end
        end
    end

    initial begin
        int n;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                n = nbytes(mem_size[l]);
                v = $urandom();
                for (int i = 0; i < n; i++)
                    v[8*(n-1-i) +: 8] = mem_model[l][9'(mem_addr[l] + 9'(i))];
                mem_dout[l] = v;
            end
        end
    end

    // Monitor: checks the memory window against the in-flight request, pops on Done.
    initial begin
        exp_t cur;
        en_cnt[0] = 0;
        en_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (rst_n !== 1'b1) begin
                    en_cnt[l] = 0;
                end else begin
                    if (mem_en[l] === 1'b1) begin
                        en_cnt[l] = en_cnt[l] + 1;
                        if (sbq[l].size() == 0) begin
                            check($sformatf("L%0d_unexpected_memenable", l), 32'(mem_en[l]), 32'd0);
                        end else begin
                            cur = sbq[l][0];
                            check($sformatf("L%0d_mem_address", l), 32'(mem_addr[l]), 32'(cur.addr));
                            check($sformatf("L%0d_mem_readwrite", l), 32'(mem_rw[l]), 32'(cur.store));
                            check($sformatf("L%0d_mem_se", l), 32'(mem_se[l]), 32'(cur.se));
                            check($sformatf("L%0d_mem_size", l), 32'(mem_size[l]),
                                  32'((cur.size == 2'b11) ? 2'b10 : cur.size));
                            if (cur.store)
                                check($sformatf("L%0d_mem_datain", l), mem_din[l], cur.wdata);
                        end
                    end
                    if (done[l] === 1'b1) begin
                        if (sbq[l].size() == 0) begin
                            check($sformatf("L%0d_unexpected_done", l), 32'(done[l]), 32'd0);
                        end else begin
                            cur = sbq[l].pop_front();
                            check($sformatf("L%0d_done_cycle", l), 32'(edge_cnt), 32'(cur.done_edge));
                            check($sformatf("L%0d_fault", l), 32'(fault[l]), 32'(cur.fault));
                            check($sformatf("L%0d_rdata", l), rdata[l], cur.rdata);
                            check($sformatf("L%0d_memenable_cycles", l), 32'(en_cnt[l]), 32'(cur.en_cycles));
                            check($sformatf("L%0d_ready_in_done", l), 32'(ready[l]), 32'd0);
                        end
                        en_cnt[l] = 0;
                    end else if (fault[l] === 1'b1) begin
                        check($sformatf("L%0d_fault_without_done", l), 32'(fault[l]), 32'd0);
                    end
                end
            end
        end
    end

    // Reference model: computes the outcome of a request accepted on edge k and queues it.
    task automatic model_push(input int l, input bit st, input bit [1:0] sz, input bit s,
                              input bit [8:0] a, input bit [31:0] wd, input int k, output bit f);
        exp_t e;
        int n;
        longint v;
        n = nbytes(sz);
        f = (int'(a) + n - 1) > 511;
`ifdef ALIGN_CHECK_EN
        if (n == 2 && (int'(a) % 2) != 0) f = 1'b1;
        if (n == 4 && (int'(a) % 4) != 0) f = 1'b1;
`endif
        if (!f) begin
            if (st) begin
                for (int i = 0; i < n; i++)
                    ref_mem[l][int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < n; i++)
                    v = v * 256 + longint'(ref_mem[l][int'(a) + i]);
                if (s && v >= (64'sd1 <<< (8 * n - 1)))
                    v = v - (64'sd1 <<< (8 * n));
                ref_rdata[l] = 32'(v);
            end
        end
        e.store     = st;
        e.size      = sz;
        e.se        = s;
        e.addr      = a;
        e.wdata     = wd;
        e.fault     = f;
        e.rdata     = ref_rdata[l];
        e.done_edge = f ? k : k + 1 + wait_of(l);
        e.en_cycles = f ? 0 : wait_of(l) + 1;
        sbq[l].push_back(e);
    endtask

    task automatic wait_ready(input int l);
        int g;
        g = 0;
        @(negedge clk);
        while (ready[l] !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (ready[l] !== 1'b1)
            check($sformatf("L%0d_ready_timeout", l), 32'(ready[l]), 32'd1);
    endtask

    task automatic issue(input int l, input bit st, input bit [1:0] sz, input bit s,
                         input bit [8:0] a, input bit [31:0] wd);
        bit f;
        wait_ready(l);
        req[l]   = 1'b1;
        store[l] = st;
        size[l]  = sz;
        se[l]    = s;
        addr[l]  = a;
        wdata[l] = wd;
        model_push(l, st, sz, s, a, wd, edge_cnt + 1, f);
        @(posedge clk);
        #1 req[l] = 1'b0;
    endtask

    task automatic drain(input int l);
        int g;
        g = 0;
        while (sbq[l].size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq[l].size() != 0) begin
            check($sformatf("L%0d_drain_timeout", l), 32'(sbq[l].size()), 32'd0);
            sbq[l].delete();
        end
    endtask

    task automatic random_ops(input int l, input int count);
        bit [8:0] a;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 9) < 2) a = 9'($urandom_range(500, 511));
            else                          a = 9'($urandom_range(0, 31));
            issue(l, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain(l);
    endtask

    // Req held for ten edges: the model predicts accepts purely from the busy time per request.
    task automatic hold_test(input int l, input bit [8:0] a);
        int k0;
        int free_edge;
        bit f;
        wait_ready(l);
        k0        = edge_cnt + 1;
        free_edge = k0;
        req[l]    = 1'b1;
        store[l]  = 1'b0;
        size[l]   = 2'b10;
        se[l]     = 1'b0;
        addr[l]   = a;
        wdata[l]  = 32'h0;
        for (int j = 0; j < 10; j++) begin
            if (k0 + j >= free_edge) begin
                model_push(l, 1'b0, 2'b10, 1'b0, a, 32'h0, k0 + j, f);
                free_edge = k0 + j + (f ? 2 : wait_of(l) + 3);
            end
            @(negedge clk);
        end
        req[l] = 1'b0;
        drain(l);
    endtask

    initial begin
        logic [31:0] exp_half;
        for (int l = 0; l < 2; l++) begin
            req[l] = 1'b0; store[l] = 1'b0; size[l] = 2'b00; se[l] = 1'b0;
            addr[l] = 9'd0; wdata[l] = 32'd0; mem_dout[l] = 32'd0; ref_rdata[l] = 32'd0;
            for (int i = 0; i < 512; i++) begin
                mem_model[l][i] = 8'($urandom());
                ref_mem[l][i]   = mem_model[l][i];
            end
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("L%0d_rst_ready", l),   32'(ready[l]),    32'd1);
            check($sformatf("L%0d_rst_done", l),    32'(done[l]),     32'd0);
            check($sformatf("L%0d_rst_fault", l),   32'(fault[l]),    32'd0);
            check($sformatf("L%0d_rst_rdata", l),   rdata[l],         32'd0);
            check($sformatf("L%0d_rst_men", l),     32'(mem_en[l]),   32'd0);
            check($sformatf("L%0d_rst_mrw", l),     32'(mem_rw[l]),   32'd0);
            check($sformatf("L%0d_rst_mse", l),     32'(mem_se[l]),   32'd0);
            check($sformatf("L%0d_rst_msize", l),   32'(mem_size[l]), 32'd0);
            check($sformatf("L%0d_rst_maddr", l),   32'(mem_addr[l]), 32'd0);
            check($sformatf("L%0d_rst_mdin", l),    mem_din[l],       32'd0);
        end
        rst_n = 1'b1;

        // Directed sequence on the zero-wait instance.
        issue(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
        drain(0);
        check("dir_load_word", rdata[0], 32'hDEADBEEF);
        issue(0, 1'b0, 2'b00, 1'b1, 9'h010, 32'h0);
        drain(0);
        check("dir_load_byte_se", rdata[0], 32'hFFFFFFDE);
        issue(0, 1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
        drain(0);
        check("dir_load_byte_ze", rdata[0], 32'h000000DE);
        issue(0, 1'b0, 2'b01, 1'b1, 9'h012, 32'h0);
        drain(0);
        check("dir_load_half_se", rdata[0], 32'hFFFFBEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 9'h1FE, 32'h0);
        drain(0);
        check("dir_range_fault_rdata_held", rdata[0], 32'hFFFFBEEF);
        issue(0, 1'b0, 2'b11, 1'b0, 9'h1FD, 32'h0);
        issue(0, 1'b0, 2'b01, 1'b0, 9'h1FF, 32'h0);
        issue(0, 1'b0, 2'b01, 1'b0, 9'h011, 32'h0);
        drain(0);
`ifdef ALIGN_CHECK_EN
        exp_half = 32'hFFFFBEEF;
`else
        exp_half = 32'h0000ADBE;
`endif
        check("dir_load_half_odd", rdata[0], exp_half);

        random_ops(0, 40);
        random_ops(1, 30);
        hold_test(0, 9'h010);
        hold_test(1, 9'h020);

        // Reset during the second ACCESS cycle of a three-wait load.
        drain(0);
        issue(1, 1'b0, 2'b10, 1'b0, 9'h008, 32'h0);
        @(posedge clk);
        #2;
        check("abort_men_before", 32'(mem_en[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_men_dropped", 32'(mem_en[1]), 32'd0);
        check("abort_ready", 32'(ready[1]), 32'd1);
        check("abort_done", 32'(done[1]), 32'd0);
        sbq[1].delete();
        ref_rdata[0] = 32'd0;
        ref_rdata[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_ready_after", 32'(ready[1]), 32'd1);
        check("abort_rdata_after", rdata[1], 32'd0);
        issue(1, 1'b1, 2'b01, 1'b0, 9'h030, 32'h00008001);
        issue(1, 1'b0, 2'b01, 1'b1, 9'h030, 32'h0);
        drain(1);
        check("post_abort_load", rdata[1], 32'hFFFF8001);

        drain(0);
        drain(1);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
